alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Sequential front-end that feeds the 32-bit combinational ALU and captures its outputs.
- Accepts operation requests (a, b, opcode) over a valid/ready interface and buffers them in a small FIFO.
- Drives the ALU operand/opcode inputs, holds them for a fixed settle window, then registers result, remainder and flags.
- Presents the captured values downstream over a second valid/ready interface.

Parameters:
- N, 32, operand/result width; must match the ALU.
- DEPTH, 4, request FIFO entries; power of 2, ≥2.
- SETTLE, 2, cycles the ALU inputs are held before capture; ≥1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid & in_ready.
- in_a  input  N  operand A (signed).
- in_b  input  N  operand B (signed).
- in_opcode  input  4  ALU opcode; 0000..1001 legal.
- alu_a  output  N  registered drive to ALU a.
- alu_b  output  N  registered drive to ALU b.
- alu_opcode  output  4  registered drive to ALU opcode.
- alu_result  input  N  ALU result.
- alu_remainder  input  N  ALU remainder.
- alu_carry_out  input  1  ALU carry_out.
- alu_zero  input  1  ALU zero.
- alu_overflow  input  1  ALU overflow.
- out_valid  output  1  response valid.
- out_ready  input  1  downstream accept.
- out_result  output  N  captured result.
- out_remainder  output  N  captured remainder.
- out_opcode  output  4  opcode of this response.
- out_flags  output  5  {div_zero, illegal, overflow, zero, carry}.
- busy  output  1  high when state != IDLE or FIFO non-empty.
- ops_done  output  16  count of responses handed off (out_valid & out_ready); wraps 0xFFFF->0.

Behaviour:
- Reset (async, immediate):
  - FIFO emptied; state IDLE; in_ready=1; out_valid=0.
  - out_result, out_remainder, out_flags, out_opcode, ops_done all 0.
  - alu_a=0, alu_b=0, alu_opcode=4'b1111 (no ALU mode active).
- Reset mid-operation discards all queued and in-flight requests; no response is produced for them.
- Input side:
  - in_ready = !fifo_full (registered count only; no same-cycle pop pass-through).
  - Push on in_valid & in_ready.
  - Simultaneous push and pop is allowed; count is unchanged.
- FSM states:
  - IDLE: if FIFO non-empty, pop head into alu_a/alu_b/alu_opcode, load settle counter = SETTLE-1, go to DRIVE.
  - DRIVE: ALU inputs held stable.
    - If counter != 0: decrement.
    - If counter == 0: capture, set out_valid=1, go to HOLD.
  - HOLD: out_valid held, all out_* stable until out_ready.
    - On out_valid & out_ready: ops_done++, out_valid=0.
    - Same edge: if FIFO non-empty, pop next into ALU regs and go to DRIVE; else go to IDLE.
- alu_* registers retain their last value in IDLE/HOLD; they change only on pop.
- Capture rules, evaluated on registered alu_opcode/alu_b:
  - Legal opcode, not div-by-zero: out_result=alu_result, out_remainder=alu_remainder.
    - Flags = {0, 0, alu_overflow, alu_zero, alu_carry_out}.
  - Opcode 1001 with alu_b==0: out_result=0, out_remainder=0 (X from ALU never propagated).
    - Flags = {1, 0, 1, 0, 0}.
  - Opcode > 1001: ALU outputs ignored; out_result=0, out_remainder=0.
    - Flags = {0, 1, 0, 0, 0}.
    - Same latency as a legal op.
  - out_opcode = alu_opcode.
- Latency, with the accept edge as edge 0:
  - Pop at edge 1 (state was IDLE, FIFO empty before).
  - Capture at edge 1+SETTLE.
  - out_valid high from that edge; SETTLE=2 gives out_valid after edge 3.
- Throughput with out_ready tied high: one response per SETTLE+1 cycles.
- Responses leave in request order; no reordering or drop.

Test Plan:
- Reset, then ADD (0110) a=0x7FFFFFFF, b=1, out_ready=1 -> out_valid after edge 3; out_result=0x80000000; flags overflow=1, carry=0, illegal=0, div_zero=0; ops_done=1.
- DIV (1001) a=100, b=0 -> out_result=0, out_remainder=0; flags={1,0,1,0,0}, no X on any output. Then DIV a=-7, b=2 -> out_result/out_remainder equal the ALU values for that pair (golden model).
- Opcode 1100, a=5, b=3 -> out_result=0, flags={0,1,0,0,0}; out_opcode=1100; same latency as ADD.
- Backpressure, out_ready=0: push 5 requests back-to-back -> in_ready drops after DEPTH requests buffered plus one in-flight; outputs hold stable. Release out_ready -> 5 responses in order, ops_done=5.
- Reset asserted in DRIVE with 2 queued -> out_valid=0, alu_opcode=1111, in_ready=1 immediately, busy=0; no further responses.
- ops_done preloaded to 0xFFFF via 65535 ops (or force) -> next handoff wraps to 0x0000. Simultaneous push+pop with FIFO at DEPTH-1 -> count unchanged, in_ready stays 1.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Request, ALU-drive and response buses of the ALU operation sequencer.
// The slave modport is the sequencer's view; master is its environment.
interface alu_op_sequencer_if #(
   parameter int N = 32
);
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  in_a;
   logic [N-1:0]  in_b;
   logic [3:0]    in_opcode;

   logic [N-1:0]  alu_a;
   logic [N-1:0]  alu_b;
   logic [3:0]    alu_opcode;
   logic [N-1:0]  alu_result;
   logic [N-1:0]  alu_remainder;
   logic          alu_carry_out;
   logic          alu_zero;
   logic          alu_overflow;

   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  out_result;
   logic [N-1:0]  out_remainder;
   logic [3:0]    out_opcode;
   logic [4:0]    out_flags;

   modport slave (
      input  in_valid, in_a, in_b, in_opcode,
      output in_ready,
      output alu_a, alu_b, alu_opcode,
      input  alu_result, alu_remainder, alu_carry_out, alu_zero, alu_overflow,
      output out_valid, out_result, out_remainder, out_opcode, out_flags,
      input  out_ready
   );

   modport master (
      output in_valid, in_a, in_b, in_opcode,
      input  in_ready,
      input  alu_a, alu_b, alu_opcode,
      output alu_result, alu_remainder, alu_carry_out, alu_zero, alu_overflow,
      input  out_valid, out_result, out_remainder, out_opcode, out_flags,
      output out_ready
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Buffers ALU requests in a FIFO, drives the combinational ALU for a settle
// window, captures result/remainder/flags and hands them downstream.
module alu_op_sequencer #(
   parameter int N      = 32,
   parameter int DEPTH  = 4,
   parameter int SETTLE = 2
) (
   input  logic               clk,
   input  logic               rst,
   alu_op_sequencer_if.slave  bus,
   output logic               busy,
   output logic [15:0]        ops_done
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE - 1);
   localparam logic [AW:0]   DEPTH_CNT   = (AW + 1)'(DEPTH);
   localparam logic [3:0]    OP_DIV      = 4'b1001;
   localparam logic [3:0]    OP_NONE     = 4'b1111;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   typedef struct packed {
      logic [N-1:0] result;
      logic [N-1:0] remainder;
      logic [4:0]   flags;
   } cap_t;

   // Flags are {div_zero, illegal, overflow, zero, carry}; ALU data is never
   // forwarded for illegal opcodes or a zero divisor, so X cannot leak out.
   function automatic cap_t capture_fn(
      input logic [3:0]   op,
      input logic [N-1:0] b,
      input logic [N-1:0] res,
      input logic [N-1:0] rem,
      input logic         cy,
      input logic         zr,
      input logic         ov
   );
      cap_t c;
      if (op > OP_DIV) begin
         c.result    = {N{1'b0}};
         c.remainder = {N{1'b0}};
         c.flags     = 5'b01000;
      end else if ((op == OP_DIV) && (b == {N{1'b0}})) begin
         c.result    = {N{1'b0}};
         c.remainder = {N{1'b0}};
         c.flags     = 5'b10100;
      end else begin
         c.result    = res;
         c.remainder = rem;
         c.flags     = {1'b0, 1'b0, ov, zr, cy};
      end
      return c;
   endfunction

   state_t         state_q, state_d;
   logic [CW-1:0]  settle_q, settle_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [AW:0]    count_q, count_d;
   logic           in_ready_q, in_ready_d;
   logic           busy_q, busy_d;
   logic [N-1:0]   alu_a_q, alu_a_d;
   logic [N-1:0]   alu_b_q, alu_b_d;
   logic [3:0]     alu_opcode_q, alu_opcode_d;
   logic           out_valid_q, out_valid_d;
   logic [N-1:0]   out_result_q, out_result_d;
   logic [N-1:0]   out_remainder_q, out_remainder_d;
   logic [3:0]     out_opcode_q, out_opcode_d;
   logic [4:0]     out_flags_q, out_flags_d;
   logic [15:0]    ops_done_q, ops_done_d;

   logic [N-1:0]   mem_a_q  [DEPTH];
   logic [N-1:0]   mem_b_q  [DEPTH];
   logic [3:0]     mem_op_q [DEPTH];

   logic           push;
   logic           pop;
   logic           fifo_empty;
   cap_t           cap;

   assign push       = bus.in_valid & in_ready_q;
   assign fifo_empty = (count_q == {(AW + 1){1'b0}});
   assign cap        = capture_fn(alu_opcode_q, alu_b_q, bus.alu_result,
                                  bus.alu_remainder, bus.alu_carry_out,
                                  bus.alu_zero, bus.alu_overflow);

   // Sequencer FSM: pop into the ALU drive registers, settle, capture, hand off.
   always_comb begin
      state_d         = state_q;
      settle_d        = settle_q;
      alu_a_d         = alu_a_q;
      alu_b_d         = alu_b_q;
      alu_opcode_d    = alu_opcode_q;
      out_valid_d     = out_valid_q;
      out_result_d    = out_result_q;
      out_remainder_d = out_remainder_q;
      out_opcode_d    = out_opcode_q;
      out_flags_d     = out_flags_q;
      ops_done_d      = ops_done_q;
      pop             = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop          = 1'b1;
               alu_a_d      = mem_a_q[rd_ptr_q];
               alu_b_d      = mem_b_q[rd_ptr_q];
               alu_opcode_d = mem_op_q[rd_ptr_q];
               settle_d     = SETTLE_LOAD;
               state_d      = S_DRIVE;
            end else begin
               state_d      = S_IDLE;
            end
         end
         S_DRIVE: begin
            if (settle_q != {CW{1'b0}}) begin
               settle_d = settle_q - CW'(1);
            end else begin
               out_result_d    = cap.result;
               out_remainder_d = cap.remainder;
               out_flags_d     = cap.flags;
               out_opcode_d    = alu_opcode_q;
               out_valid_d     = 1'b1;
               state_d         = S_HOLD;
            end
         end
         S_HOLD: begin
            if (bus.out_ready) begin
               ops_done_d  = ops_done_q + 16'd1;
               out_valid_d = 1'b0;
               if (!fifo_empty) begin
                  pop          = 1'b1;
                  alu_a_d      = mem_a_q[rd_ptr_q];
                  alu_b_d      = mem_b_q[rd_ptr_q];
                  alu_opcode_d = mem_op_q[rd_ptr_q];
                  settle_d     = SETTLE_LOAD;
                  state_d      = S_DRIVE;
               end else begin
                  state_d      = S_IDLE;
               end
            end else begin
               state_d = S_HOLD;
            end
         end
         default: begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // FIFO pointers and occupancy; in_ready/busy are registered from next state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + (AW + 1)'(1);
         2'b01:   count_d = count_q - (AW + 1)'(1);
         default: count_d = count_q;
      endcase

      in_ready_d = (count_d != DEPTH_CNT);
      busy_d     = (state_d != S_IDLE) || (count_d != {(AW + 1){1'b0}});
   end

   // Request storage; reads are gated by the occupancy count, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a_q[wr_ptr_q]  <= bus.in_a;
         mem_b_q[wr_ptr_q]  <= bus.in_b;
         mem_op_q[wr_ptr_q] <= bus.in_opcode;
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= S_IDLE;
         settle_q        <= {CW{1'b0}};
         wr_ptr_q        <= {AW{1'b0}};
         rd_ptr_q        <= {AW{1'b0}};
         count_q         <= {(AW + 1){1'b0}};
         in_ready_q      <= 1'b1;
         busy_q          <= 1'b0;
         alu_a_q         <= {N{1'b0}};
         alu_b_q         <= {N{1'b0}};
         alu_opcode_q    <= OP_NONE;
         out_valid_q     <= 1'b0;
         out_result_q    <= {N{1'b0}};
         out_remainder_q <= {N{1'b0}};
         out_opcode_q    <= 4'b0000;
         out_flags_q     <= 5'b00000;
         ops_done_q      <= 16'd0;
      end else begin
         state_q         <= state_d;
         settle_q        <= settle_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         count_q         <= count_d;
         in_ready_q      <= in_ready_d;
         busy_q          <= busy_d;
         alu_a_q         <= alu_a_d;
         alu_b_q         <= alu_b_d;
         alu_opcode_q    <= alu_opcode_d;
         out_valid_q     <= out_valid_d;
         out_result_q    <= out_result_d;
         out_remainder_q <= out_remainder_d;
         out_opcode_q    <= out_opcode_d;
         out_flags_q     <= out_flags_d;
         ops_done_q      <= ops_done_d;
      end
   end

   assign bus.in_ready      = in_ready_q;
   assign bus.alu_a         = alu_a_q;
   assign bus.alu_b         = alu_b_q;
   assign bus.alu_opcode    = alu_opcode_q;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_result    = out_result_q;
   assign bus.out_remainder = out_remainder_q;
   assign bus.out_opcode    = out_opcode_q;
   assign bus.out_flags     = out_flags_q;
   assign busy              = busy_q;
   assign ops_done          = ops_done_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed, table-driven bench for alu_op_sequencer with a behavioural ALU.
module tb_alu_op_sequencer;
   logic        clk;
   logic        rst;
   logic        busy;
   logic [15:0] ops_done;
   int          n_checks;
   int          n_fail;

   alu_op_sequencer_if #(.N(32)) bus ();

   alu_op_sequencer #(.N(32), .DEPTH(4), .SETTLE(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .busy     (busy),
      .ops_done (ops_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU; illegal opcodes and divide-by-zero return junk on purpose.
   logic [32:0] sum33;
   always_comb begin
      sum33             = 33'd0;
      bus.alu_result    = 32'd0;
      bus.alu_remainder = 32'd0;
      bus.alu_carry_out = 1'b0;
      bus.alu_overflow  = 1'b0;
      case (bus.alu_opcode)
         4'b0110: begin
            sum33             = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            bus.alu_result    = sum33[31:0];
            bus.alu_carry_out = sum33[32];
            bus.alu_overflow  = (bus.alu_a[31] == bus.alu_b[31]) && (sum33[31] != bus.alu_a[31]);
         end
         4'b0010: bus.alu_result = bus.alu_a ^ bus.alu_b;
         4'b1001: begin
            if (bus.alu_b == 32'd0) begin
               bus.alu_result    = 32'hBAD0_BAD0;
               bus.alu_remainder = 32'hBAD0_BAD0;
               bus.alu_carry_out = 1'b1;
            end else begin
               bus.alu_result    = $signed(bus.alu_a) / $signed(bus.alu_b);
               bus.alu_remainder = $signed(bus.alu_a) % $signed(bus.alu_b);
            end
         end
         4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111: begin
            bus.alu_result    = 32'hDEAD_BEEF;
            bus.alu_remainder = 32'hFEED_FACE;
            bus.alu_carry_out = 1'b1;
            bus.alu_overflow  = 1'b1;
         end
         default: bus.alu_result = bus.alu_a | bus.alu_b;
      endcase
   end
   assign bus.alu_zero = (bus.alu_opcode > 4'b1001) ? 1'b1 : (bus.alu_result == 32'd0);

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [31:0] res;
      logic [31:0] rem;
      logic [4:0]  flags;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [31:0] rem;
      logic [3:0]  op;
      logic [4:0]  flags;
   } resp_t;

   vec_t  vecs [7];
   resp_t exp_q [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic do_reset();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Called on a negedge; returns on the negedge after the accepting edge.
   task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      int t = 0;
      bus.in_valid  = 1'b1;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_opcode = op;
      while (!bus.in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("push_accept", {63'd0, bus.in_ready}, 64'd1);
      if (bus.in_ready) begin
         @(posedge clk);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int cyc = 0;
      resp_t e;
      while (exp_q.size() > 0 && cyc < budget) begin
         if (bus.out_valid) begin
            e = exp_q.pop_front();
            check("drain_result", {32'd0, bus.out_result}, {32'd0, e.res});
            check("drain_remainder", {32'd0, bus.out_remainder}, {32'd0, e.rem});
            check("drain_opcode", {60'd0, bus.out_opcode}, {60'd0, e.op});
            check("drain_flags", {59'd0, bus.out_flags}, {59'd0, e.flags});
         end
         @(negedge clk);
         cyc++;
      end
      check("drain_left", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int    k;
      int    highs;
      resp_t r;

      n_checks = 0;
      n_fail   = 0;
      bus.in_a = 32'd0;
      bus.in_b = 32'd0;
      bus.in_opcode = 4'b0000;

      vecs[0] = '{"add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 4'b0110, 32'h8000_0000, 32'h0, 5'b00100};
      vecs[1] = '{"div_zero",  32'd100,       32'd0,         4'b1001, 32'h0,         32'h0, 5'b10100};
      vecs[2] = '{"div_neg",   32'hFFFF_FFF9, 32'd2,         4'b1001, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 5'b00000};
      vecs[3] = '{"illegal_c", 32'd5,         32'd3,         4'b1100, 32'h0,         32'h0, 5'b01000};
      vecs[4] = '{"add_wrap",  32'hFFFF_FFFF, 32'd1,         4'b0110, 32'h0,         32'h0, 5'b00011};
      vecs[5] = '{"xor",       32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'b0010, 32'hFFFF_FFFF, 32'h0, 5'b00000};
      vecs[6] = '{"illegal_f", 32'd1,         32'd2,         4'b1111, 32'h0,         32'h0, 5'b01000};

      do_reset();
      check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
      check("rst_alu_opcode", {60'd0, bus.alu_opcode}, 64'hF);
      check("rst_alu_a", {32'd0, bus.alu_a}, 64'd0);
      check("rst_alu_b", {32'd0, bus.alu_b}, 64'd0);
      check("rst_out_result", {32'd0, bus.out_result}, 64'd0);
      check("rst_out_flags", {59'd0, bus.out_flags}, 64'd0);
      check("rst_out_opcode", {60'd0, bus.out_opcode}, 64'd0);
      check("rst_ops_done", {48'd0, ops_done}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);

      // Single requests: latency from accept edge, captured values, counter.
      for (int i = 0; i < 7; i++) begin
         push(vecs[i].a, vecs[i].b, vecs[i].op);
         k = 0;
         while (!bus.out_valid && k < 20) begin
            @(negedge clk);
            k++;
         end
         check({vecs[i].name, "_latency"}, 64'(k), 64'd3);
         check({vecs[i].name, "_result"}, {32'd0, bus.out_result}, {32'd0, vecs[i].res});
         check({vecs[i].name, "_remainder"}, {32'd0, bus.out_remainder}, {32'd0, vecs[i].rem});
         check({vecs[i].name, "_opcode"}, {60'd0, bus.out_opcode}, {60'd0, vecs[i].op});
         check({vecs[i].name, "_flags"}, {59'd0, bus.out_flags}, {59'd0, vecs[i].flags});
         @(negedge clk);
         check({vecs[i].name, "_ops_done"}, {48'd0, ops_done}, 64'(i + 1));
         check({vecs[i].name, "_valid_drop"}, {63'd0, bus.out_valid}, 64'd0);
      end

      // Backpressure: four buffered plus one in flight fills the sequencer.
      do_reset();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         push(32'(10 * i), 32'd1, 4'b0110);
         r = '{32'(10 * i + 1), 32'd0, 4'b0110, 5'b00000};
         exp_q.push_back(r);
      end
      check("bp_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
      for (int i = 0; i < 3; i++) begin
         check("bp_hold_valid", {63'd0, bus.out_valid}, 64'd1);
         check("bp_hold_result", {32'd0, bus.out_result}, 64'd1);
         check("bp_hold_alu_a", {32'd0, bus.alu_a}, 64'd0);
         check("bp_hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      drain(100);
      check("bp_ops_done", {48'd0, ops_done}, 64'd5);
      check("bp_busy_idle", {63'd0, busy}, 64'd0);

      // Reset while driving the ALU with two requests still queued.
      do_reset();
      push(32'd1, 32'd2, 4'b0110);
      push(32'd3, 32'd4, 4'b0110);
      push(32'd5, 32'd6, 4'b0110);
      check("mid_busy_before", {63'd0, busy}, 64'd1);
      rst = 1'b1;
      #1;
      check("mid_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("mid_alu_opcode", {60'd0, bus.alu_opcode}, 64'hF);
      check("mid_in_ready", {63'd0, bus.in_ready}, 64'd1);
      check("mid_busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      highs = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.out_valid) highs++;
      end
      check("mid_no_response", 64'(highs), 64'd0);
      check("mid_ops_done", {48'd0, ops_done}, 64'd0);

      // Counter wrap from 0xFFFF.
      force dut.ops_done_q = 16'hFFFF;
      #1;
      release dut.ops_done_q;
      @(negedge clk);
      check("wrap_preload", {48'd0, ops_done}, 64'hFFFF);
      push(32'd2, 32'd2, 4'b0110);
      r = '{32'd4, 32'd0, 4'b0110, 5'b00000};
      exp_q.push_back(r);
      drain(20);
      check("wrap_ops_done", {48'd0, ops_done}, 64'd0);

      // Simultaneous push and pop with the FIFO one short of full.
      do_reset();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         push(32'(100 + i), 32'd0, 4'b0010);
         r = '{32'(100 + i), 32'd0, 4'b0010, 5'b00000};
         exp_q.push_back(r);
      end
      check("pp_in_ready_before", {63'd0, bus.in_ready}, 64'd1);
      check("pp_valid_before", {63'd0, bus.out_valid}, 64'd1);
      r = exp_q.pop_front();
      check("pp_first_result", {32'd0, bus.out_result}, {32'd0, r.res});
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_a      = 32'd104;
      bus.in_b      = 32'd0;
      bus.in_opcode = 4'b0010;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      r = '{32'd104, 32'd0, 4'b0010, 5'b00000};
      exp_q.push_back(r);
      check("pp_in_ready_after", {63'd0, bus.in_ready}, 64'd1);
      check("pp_ops_done_1", {48'd0, ops_done}, 64'd1);
      drain(100);
      check("pp_ops_done", {48'd0, ops_done}, 64'd5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
